fpu_cpx_tx: RTL

Return-path transmitter of the FPU: collects completed results from the add, multiply and divide pipes, arbitrates them into a small result queue, and sends one CPX return packet per result using a request/grant handshake. It is the CPX-side counterpart of the PCX capture and input-queue path, closing each request by its 5-bit request ID.

---
 rtl/fpu_out_pkg.sv | 56 +++++
 rtl/fpu_cpx_tx_if.sv | 36 +++
 rtl/fpu_out_fifo.sv | 52 +++++
 rtl/fpu_cpx_tx.sv | 90 +++++++++
 4 files changed

// File: rtl/fpu_out_pkg.sv
// fpu_out_pkg: shared field layout for the FPU CPX return path.
// Payload and CPX packet bit positions plus pack/format helpers.
package fpu_out_pkg;

  localparam int PAYLOAD_W = 77;
  localparam int CPX_W     = 145;

  localparam logic [3:0] RTNTYPE_FP = 4'b1000;

  localparam int P_RES  = 0;
  localparam int P_EXC  = 64;
  localparam int P_FCC  = 69;
  localparam int P_FCCV = 71;
  localparam int P_ID   = 72;

  localparam int C_RES  = 0;
  localparam int C_EXC  = 127;
  localparam int C_FCC  = 132;
  localparam int C_FCCV = 134;
  localparam int C_ID   = 135;
  localparam int C_RTN  = 140;
  localparam int C_VLD  = 144;

  function automatic logic [PAYLOAD_W-1:0] pack(
    input logic [4:0]  id,
    input logic        fccv,
    input logic [1:0]  fcc,
    input logic [4:0]  exc,
    input logic [63:0] res
  );
    logic [PAYLOAD_W-1:0] p;
    p = '0;
    p[P_ID+:5]   = id;
    p[P_FCCV]    = fccv;
    p[P_FCC+:2]  = fcc;
    p[P_EXC+:5]  = exc;
    p[P_RES+:64] = res;
    return p;
  endfunction

  function automatic logic [CPX_W-1:0] cpx_pkt(
    input logic [PAYLOAD_W-1:0] p
  );
    logic [CPX_W-1:0] c;
    c = '0;
    c[C_VLD]     = 1'b1;
    c[C_RTN+:4]  = RTNTYPE_FP;
    c[C_ID+:5]   = p[P_ID+:5];
    c[C_FCCV]    = p[P_FCCV];
    c[C_FCC+:2]  = p[P_FCC+:2];
    c[C_EXC+:5]  = p[P_EXC+:5];
    c[C_RES+:64] = p[P_RES+:64];
    return c;
  endfunction

endpackage

// File: rtl/fpu_cpx_tx_if.sv
// fpu_cpx_tx_if: pipe result inputs, stalls and CPX request/grant.
// master = pipes/CPX side, slave = fpu_cpx_tx.
interface fpu_cpx_tx_if;
  logic        add_vld, mul_vld, div_vld;
  logic [4:0]  add_id, mul_id, div_id;
  logic [63:0] add_res, mul_res, div_res;
  logic [4:0]  add_exc, mul_exc, div_exc;
  logic        add_fcc_vld;
  logic [1:0]  add_fcc;
  logic        add_stall, mul_stall, div_stall;
  logic        fp_cpx_req;
  logic        cpx_fp_grant;
  logic [144:0] fp_cpx_data;

  modport master (
    output add_vld, mul_vld, div_vld,
    output add_id, mul_id, div_id,
    output add_res, mul_res, div_res,
    output add_exc, mul_exc, div_exc,
    output add_fcc_vld, add_fcc,
    output cpx_fp_grant,
    input  add_stall, mul_stall, div_stall,
    input  fp_cpx_req, fp_cpx_data
  );

  modport slave (
    input  add_vld, mul_vld, div_vld,
    input  add_id, mul_id, div_id,
    input  add_res, mul_res, div_res,
    input  add_exc, mul_exc, div_exc,
    input  add_fcc_vld, add_fcc,
    input  cpx_fp_grant,
    output add_stall, mul_stall, div_stall,
    output fp_cpx_req, fp_cpx_data
  );
endinterface

// File: rtl/fpu_out_fifo.sv
// fpu_out_fifo: DEPTH-entry result queue with count register.
// Push is refused when full, pop is ignored when empty.
module fpu_out_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 77
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic          push_ok, pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; validity lives in count.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= din;
  end

endmodule

// File: rtl/fpu_cpx_tx.sv
// fpu_cpx_tx: arbitrates add/mul/div results into a queue, sends CPX packets.
// FPU_OUT_RR_ARB_EN: round-robin between add and mul (div stays on top).
module fpu_cpx_tx
  import fpu_out_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic           rclk,
  input logic           arst_l,
  fpu_cpx_tx_if.slave   bus
);

  logic                 full, empty;
  logic                 push, pop;
  logic [PAYLOAD_W-1:0] din, head;
  logic                 win_div, win_mul, win_add;
  logic                 mul_pref;
  logic [CPX_W-1:0]     data_q;

`ifdef FPU_OUT_RR_ARB_EN
  logic last_mul;

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l)
      last_mul <= 1'b0;
    else if (push & (win_mul | win_add))
      last_mul <= win_mul;
  end

  assign mul_pref = ~last_mul;
`else
  assign mul_pref = 1'b1;
`endif

  always_comb begin
    win_div = bus.div_vld;
    win_mul = ~bus.div_vld & bus.mul_vld &
              (mul_pref | ~bus.add_vld);
    win_add = ~bus.div_vld & bus.add_vld & ~win_mul;
  end

  always_comb begin
    din = '0;
    unique case (1'b1)
      win_div: din = pack(bus.div_id, 1'b0, 2'b00,
                          bus.div_exc, bus.div_res);
      win_mul: din = pack(bus.mul_id, 1'b0, 2'b00,
                          bus.mul_exc, bus.mul_res);
      win_add: din = pack(bus.add_id, bus.add_fcc_vld,
                          bus.add_fcc, bus.add_exc,
                          bus.add_res);
      default: din = '0;
    endcase
  end

  // Stalls see only vld inputs and registered state, never the grant.
  assign push          = ~full & (win_div | win_mul | win_add);
  assign bus.div_stall = bus.div_vld & full;
  assign bus.mul_stall = bus.mul_vld & (full | ~win_mul);
  assign bus.add_stall = bus.add_vld & (full | ~win_add);

  assign bus.fp_cpx_req = ~empty;
  assign pop            = bus.cpx_fp_grant & ~empty;

  fpu_out_fifo #(
    .DEPTH (DEPTH),
    .W     (PAYLOAD_W)
  ) u_fifo (
    .clk   (rclk),
    .rst_n (arst_l),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l)
      data_q <= '0;
    else if (pop)
      data_q <= cpx_pkt(head);
    else
      data_q <= '0;
  end

  assign bus.fp_cpx_data = data_q;

endmodule
